// File: rtl/bj_predict_resolve.sv
// Branch/jump resolve stage with a PC-indexed 2-bit pattern-history table.
// Lookup is combinational on the fetch PC; resolution results are registered one cycle later.
module bj_predict_resolve #(
    parameter int XLEN      = 32,
    parameter int PHT_DEPTH = 16,
    parameter int IDX_LSB   = 2
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [XLEN-1:0] LOOKUP_PC,
    output logic            PRED_TAKEN,
    input  logic            VALID_IN,
    input  logic [2:0]      BRANCH_JUMP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic [XLEN-1:0] RES_PC,
    input  logic            RES_PRED,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic            CLR_CNT,
    output logic            VALID_OUT,
    output logic            PC_SEL_OUT,
    output logic            MISPREDICT,
    output logic [15:0]     MISPRED_CNT
);
    localparam int IW = $clog2(PHT_DEPTH);

    logic [PHT_DEPTH-1:0][1:0] pht;
    logic [IW-1:0]             lookup_idx;
    logic [IW-1:0]             res_idx;
    logic                      eq, slt, ult;
    logic                      taken;
    logic                      is_cond;
    logic                      accept;
    logic                      mispred;
    logic                      unused_pc_bits;

    assign lookup_idx = LOOKUP_PC[IDX_LSB+IW-1:IDX_LSB];
    assign res_idx    = RES_PC[IDX_LSB+IW-1:IDX_LSB];
    // Only the index field of each PC matters here.
    assign unused_pc_bits = ^{LOOKUP_PC, RES_PC};

    // No bypass: an update this cycle becomes visible next cycle.
    assign PRED_TAKEN = pht[lookup_idx][1];

    assign eq  = (DATA1 == DATA2);
    assign slt = ($signed(DATA1) < $signed(DATA2));
    assign ult = (DATA1 < DATA2);

    always_comb begin
        taken = 1'b0;
        case (BRANCH_JUMP)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b010:  taken = 1'b0;
            3'b011:  taken = 1'b1;
            3'b100:  taken = slt;
            3'b101:  taken = !slt;
            3'b110:  taken = ult;
            3'b111:  taken = !ult;
            default: taken = 1'b0;
        endcase
    end

    // Codes 010 (none) and 011 (jump) never train the table.
    assign is_cond = (BRANCH_JUMP[2:1] != 2'b01);
    assign accept  = VALID_IN && !STALL && !FLUSH;
    assign mispred = taken ^ RES_PRED;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            VALID_OUT  <= 1'b0;
            PC_SEL_OUT <= 1'b0;
            MISPREDICT <= 1'b0;
        end else if (FLUSH) begin
            VALID_OUT  <= 1'b0;
            PC_SEL_OUT <= 1'b0;
            MISPREDICT <= 1'b0;
        end else if (!STALL) begin
            VALID_OUT  <= accept;
            PC_SEL_OUT <= accept && taken;
            MISPREDICT <= accept && mispred;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MISPRED_CNT <= '0;
        end else if (CLR_CNT) begin
            MISPRED_CNT <= '0;
        end else if (accept && mispred && (MISPRED_CNT != 16'hFFFF)) begin
            MISPRED_CNT <= MISPRED_CNT + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
        end else if (accept && is_cond) begin
            if (taken && (pht[res_idx] != 2'b11))
                pht[res_idx] <= pht[res_idx] + 2'd1;
            else if (!taken && (pht[res_idx] != 2'b00))
                pht[res_idx] <= pht[res_idx] - 2'd1;
        end
    end
endmodule

// File: tb/tb_bj_predict_resolve.sv
// Directed bench for bj_predict_resolve: scoreboard of expected registered outputs
// plus a reference table model for the combinational prediction.
module tb_bj_predict_resolve;
    localparam int XLEN = 32, DEPTH = 16, LSB = 2, IW = 4;

    logic            CLK = 1'b0, RESET_N = 1'b0;
    logic [XLEN-1:0] LOOKUP_PC = '0, DATA1 = '0, DATA2 = '0, RES_PC = '0;
    logic [2:0]      BRANCH_JUMP = 3'b010;
    logic            VALID_IN = 0, RES_PRED = 0, STALL = 0, FLUSH = 0, CLR_CNT = 0;
    logic            PRED_TAKEN, VALID_OUT, PC_SEL_OUT, MISPREDICT;
    logic [15:0]     MISPRED_CNT;

    bj_predict_resolve #(.XLEN(XLEN), .PHT_DEPTH(DEPTH), .IDX_LSB(LSB)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .LOOKUP_PC(LOOKUP_PC), .PRED_TAKEN(PRED_TAKEN),
        .VALID_IN(VALID_IN), .BRANCH_JUMP(BRANCH_JUMP), .DATA1(DATA1), .DATA2(DATA2),
        .RES_PC(RES_PC), .RES_PRED(RES_PRED), .STALL(STALL), .FLUSH(FLUSH),
        .CLR_CNT(CLR_CNT), .VALID_OUT(VALID_OUT), .PC_SEL_OUT(PC_SEL_OUT),
        .MISPREDICT(MISPREDICT), .MISPRED_CNT(MISPRED_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        v;
        logic        s;
        logic        m;
        logic [15:0] c;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_out;
    logic [1:0]  m_pht[DEPTH];
    logic [15:0] m_cnt;
    int          pass_cnt = 0;
    int          total    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic f_taken(input logic [2:0] bj, input logic [31:0] a, input logic [31:0] b);
        case (bj)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b010: return 1'b0;
            3'b011: return 1'b1;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return !($signed(a) < $signed(b));
            3'b110: return a < b;
            default: return !(a < b);
        endcase
    endfunction

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[LSB+IW-1:LSB]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_pht[i] = 2'b01;
        m_cnt    = '0;
        last_out = '0;
        sb.delete();
    endtask

    // One cycle: apply inputs, predict, clock, compare the scoreboard head.
    task automatic drive(input logic [2:0] bj, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic pred, input logic v,
                         input logic st, input logic fl, input logic clr);
        exp_t e, got;
        logic acc, tk;
        BRANCH_JUMP = bj; DATA1 = a; DATA2 = b; RES_PC = pc; LOOKUP_PC = pc;
        RES_PRED = pred; VALID_IN = v; STALL = st; FLUSH = fl; CLR_CNT = clr;
        #1;
        chk("pred_pre", PRED_TAKEN, m_pht[idx(pc)][1]);
        acc = v && !st && !fl;
        tk  = f_taken(bj, a, b);
        if (fl)       e = '0;
        else if (st)  e = last_out;
        else begin
            e.v = acc; e.s = acc && tk; e.m = acc && (tk != pred); e.c = '0;
        end
        if (clr)                                  m_cnt = '0;
        else if (acc && tk != pred && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        e.c = m_cnt;
        if (acc && bj[2:1] != 2'b01) begin
            if (tk && m_pht[idx(pc)] != 2'b11)       m_pht[idx(pc)] = m_pht[idx(pc)] + 2'd1;
            else if (!tk && m_pht[idx(pc)] != 2'b00) m_pht[idx(pc)] = m_pht[idx(pc)] - 2'd1;
        end
        sb.push_back(e);
        last_out = e;
        @(posedge CLK); #1;
        got = sb.pop_front();
        chk("valid_out", VALID_OUT, got.v);
        chk("pc_sel_out", PC_SEL_OUT, got.s);
        chk("mispredict", MISPREDICT, got.m);
        chk("mispred_cnt", MISPRED_CNT, got.c);
        chk("pred_post", PRED_TAKEN, m_pht[idx(pc)][1]);
        VALID_IN = 0; STALL = 0; FLUSH = 0; CLR_CNT = 0;
    endtask

    initial begin
        model_reset();
        LOOKUP_PC = 32'h40;
        #8;  // reset held across an edge
        chk("rst_valid", VALID_OUT, 0);
        chk("rst_pcsel", PC_SEL_OUT, 0);
        chk("rst_misp", MISPREDICT, 0);
        chk("rst_cnt", MISPRED_CNT, 0);
        chk("rst_pred", PRED_TAKEN, 0);
        #4 RESET_N = 1'b1;

        // Signed less-than, mispredicted not-taken -> counter 01 -> 10
        drive(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 1, 0, 0, 0);
        chk("blt_valid", VALID_OUT, 1);
        chk("blt_pcsel", PC_SEL_OUT, 1);
        chk("blt_misp", MISPREDICT, 1);
        chk("blt_cnt", MISPRED_CNT, 1);
        chk("blt_pred", PRED_TAKEN, 1);

        // Unsigned compare of same operands is not-taken; three times saturates at 00
        drive(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h80, 0, 1, 0, 0, 0);
        chk("bltu_pcsel", PC_SEL_OUT, 0);
        repeat (2) drive(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h80, 0, 1, 0, 0, 0);
        // One taken from 00 lands on 01, still predicting not-taken
        drive(3'b000, 32'd5, 32'd5, 32'h80, 0, 1, 0, 0, 0);
        chk("sat_low_pred", PRED_TAKEN, 0);

        drive(3'b011, 32'd0, 32'd0, 32'h40, 0, 1, 0, 0, 0);
        chk("jump_pcsel", PC_SEL_OUT, 1);
        chk("jump_misp", MISPREDICT, 1);
        chk("jump_pht", PRED_TAKEN, 0);

        // Stall holds everything, then flush wins over stall
        drive(3'b000, 32'd7, 32'd7, 32'h44, 1, 1, 0, 0, 0);
        repeat (3) drive(3'b001, 32'd7, 32'd7, 32'h44, 1, 1, 1, 0, 0);
        chk("stall_valid", VALID_OUT, 1);
        chk("stall_pht", PRED_TAKEN, 1);
        drive(3'b001, 32'd7, 32'd7, 32'h44, 1, 1, 1, 1, 0);
        chk("flush_valid", VALID_OUT, 0);
        drive(3'b000, 32'd1, 32'd1, 32'h48, 0, 1, 0, 1, 0);
        chk("flush_noupd", PRED_TAKEN, 0);
        drive(3'b000, 32'd1, 32'd1, 32'h48, 0, 0, 0, 0, 0);

        // Sweep every code over equal, signed-negative and unsigned-large operand pairs
        for (int code = 0; code < 8; code++) begin
            drive(3'(code), 32'd3, 32'd3, 32'h48 + 32'(code * 4), 1'($urandom_range(0, 1)), 1, 0, 0, 0);
            drive(3'(code), 32'h8000_0000, 32'd1, 32'h48 + 32'(code * 4), 1'($urandom_range(0, 1)), 1, 0, 0, 0);
            drive(3'(code), 32'd1, 32'h8000_0000, 32'h48 + 32'(code * 4), 1'($urandom_range(0, 1)), 1, 0, 0, 0);
        end

        // Reset mid-operation discards the in-flight result
        drive(3'b000, 32'd2, 32'd2, 32'h40, 0, 1, 0, 0, 0);
        drive(3'b000, 32'd2, 32'd2, 32'h40, 0, 1, 0, 0, 0);
        #1 RESET_N = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", VALID_OUT, 0);
        chk("mid_rst_cnt", MISPRED_CNT, 0);
        chk("mid_rst_pred", PRED_TAKEN, 0);
        #1 RESET_N = 1'b1;
        drive(3'b101, 32'd5, 32'd3, 32'h40, 1, 1, 0, 0, 0);
        chk("post_rst_valid", VALID_OUT, 1);

        // Drive back-to-back mispredicted jumps past counter saturation
        BRANCH_JUMP = 3'b011; RES_PRED = 0; VALID_IN = 1;
        repeat (65540) begin
            @(posedge CLK);
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        #1;
        chk("cnt_sat", MISPRED_CNT, 16'hFFFF);
        chk("cnt_sat_model", MISPRED_CNT, m_cnt);
        last_out = '{v: 1'b1, s: 1'b1, m: 1'b1, c: m_cnt};
        VALID_IN = 0;
        drive(3'b011, 32'd0, 32'd0, 32'h40, 0, 1, 0, 0, 0);
        chk("cnt_hold", MISPRED_CNT, 16'hFFFF);
        drive(3'b011, 32'd0, 32'd0, 32'h40, 0, 1, 0, 0, 1);
        chk("cnt_clr", MISPRED_CNT, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
